// File: rtl/stack_sequencer_if.sv
// Command/response and operand-stack signals between decode, stack_sequencer and the stack.
// master is the sequencer's view; slave is the surrounding decode logic plus the stack.
interface stack_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_imm;
    logic [1:0]       st_op;
    logic [WIDTH-1:0] st_data;
    logic [WIDTH-1:0] st_tos;
    logic [1:0]       st_status;
    logic [1:0]       st_error;
    logic             rsp_valid;
    logic [1:0]       rsp_trap;

    modport master (
        input  cmd_valid, cmd_op, cmd_imm, st_tos, st_status, st_error,
        output cmd_ready, st_op, st_data, rsp_valid, rsp_trap
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_imm, st_tos, st_status, st_error,
        input  cmd_ready, st_op, st_data, rsp_valid, rsp_trap
    );
endinterface

// File: rtl/stack_sequencer.sv
// Runs one WASM-style stack instruction at a time against a registered stack.
// A shadow depth counter lets illegal instructions trap before the stack is touched.
module stack_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic               clk,
    input  logic               reset,
    stack_sequencer_if.master  bus,
    output logic [DEPTH+1:0]   depth,
    output logic               desync
);
    localparam logic [1:0] OP_NONE    = 2'd0;
    localparam logic [1:0] OP_PUSH    = 2'd1;
    localparam logic [1:0] OP_POP     = 2'd2;
    localparam logic [1:0] OP_REPLACE = 2'd3;
    localparam logic [1:0] STATUS_EMPTY = 2'd1;
    localparam logic [1:0] ERROR_NONE   = 2'd0;

    localparam logic [3:0] OPC_NOP   = 4'd0;
    localparam logic [3:0] OPC_CONST = 4'd1;
    localparam logic [3:0] OPC_DROP  = 4'd2;
    localparam logic [3:0] OPC_DUP   = 4'd3;
    localparam logic [3:0] OPC_ADD   = 4'd4;
    localparam logic [3:0] OPC_SUB   = 4'd5;
    localparam logic [3:0] OPC_AND   = 4'd6;
    localparam logic [3:0] OPC_OR    = 4'd7;
    localparam logic [3:0] OPC_XOR   = 4'd8;
    localparam logic [3:0] OPC_EQZ   = 4'd9;

    localparam logic [DEPTH+1:0] MAX_STACK = {1'b0, {(DEPTH+1){1'b1}}};
    localparam logic [DEPTH+1:0] DEPTH_ONE = {{(DEPTH+1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, EXEC, FETCH2, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       trap_q;
    logic             op_issued;
    logic [1:0]       trap_code;
    logic             is_binary;
    logic [WIDTH-1:0] alu;

    assign is_binary = (op_q >= OPC_ADD) && (op_q <= OPC_XOR);

    always_comb begin
        trap_code = 2'd0;
        if (op_q > OPC_EQZ)
            trap_code = 2'd3;
        else if (((op_q == OPC_DROP || op_q == OPC_DUP || op_q == OPC_EQZ) && depth == '0) ||
                 (is_binary && depth <= DEPTH_ONE))
            trap_code = 2'd1;
        else if ((op_q == OPC_CONST || op_q == OPC_DUP) && depth == MAX_STACK)
            trap_code = 2'd2;
    end

    // In FETCH2 the stack top is the deeper operand a; b was captured during the POP.
    always_comb begin
        alu = '0;
        case (op_q)
            OPC_ADD: alu = bus.st_tos + b_q;
            OPC_SUB: alu = bus.st_tos - b_q;
            OPC_AND: alu = bus.st_tos & b_q;
            OPC_OR:  alu = bus.st_tos | b_q;
            OPC_XOR: alu = bus.st_tos ^ b_q;
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= '0;
            imm_q     <= '0;
            b_q       <= '0;
            trap_q    <= 2'd0;
            op_issued <= 1'b0;
            depth     <= '0;
            desync    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q  <= bus.cmd_op;
                        imm_q <= bus.cmd_imm;
                    end
                end
                EXEC: begin
                    trap_q    <= trap_code;
                    b_q       <= bus.st_tos;
                    op_issued <= (trap_code == 2'd0) && (op_q != OPC_NOP);
                    if (trap_code == 2'd0) begin
                        if (op_q == OPC_CONST || op_q == OPC_DUP)
                            depth <= depth + DEPTH_ONE;
                        else if (op_q == OPC_DROP || is_binary)
                            depth <= depth - DEPTH_ONE;
                    end
                end
                RESP: begin
                    if ((op_issued && bus.st_error != ERROR_NONE) ||
                        ((bus.st_status == STATUS_EMPTY) != (depth == '0)))
                        desync <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_next = EXEC;
            EXEC:    state_next = (trap_code == 2'd0 && is_binary) ? FETCH2 : RESP;
            FETCH2:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
        bus.rsp_trap  = trap_q;
        bus.st_op     = OP_NONE;
        bus.st_data   = '0;
        if (state == EXEC && trap_code == 2'd0) begin
            case (op_q)
                OPC_CONST: begin
                    bus.st_op   = OP_PUSH;
                    bus.st_data = imm_q;
                end
                OPC_DUP: begin
                    bus.st_op   = OP_PUSH;
                    bus.st_data = bus.st_tos;
                end
                OPC_EQZ: begin
                    bus.st_op   = OP_REPLACE;
                    bus.st_data = {{(WIDTH-1){1'b0}}, (bus.st_tos == '0)};
                end
                OPC_DROP, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR:
                    bus.st_op = OP_POP;
                default: ;
            endcase
        end else if (state == FETCH2) begin
            bus.st_op   = OP_REPLACE;
            bus.st_data = alu;
        end
    end
endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural registered stack of capacity 3.
module tb_stack_sequencer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 1;
    localparam logic [2:0] MAX_STACK = 3'd3;

    localparam logic [1:0] OP_NONE    = 2'd0;
    localparam logic [1:0] OP_PUSH    = 2'd1;
    localparam logic [1:0] OP_POP     = 2'd2;
    localparam logic [1:0] OP_REPLACE = 2'd3;
    localparam logic [1:0] ST_NONE  = 2'd0;
    localparam logic [1:0] ST_EMPTY = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;

    localparam logic [3:0] OPC_NOP   = 4'd0;
    localparam logic [3:0] OPC_CONST = 4'd1;
    localparam logic [3:0] OPC_DROP  = 4'd2;
    localparam logic [3:0] OPC_DUP   = 4'd3;
    localparam logic [3:0] OPC_ADD   = 4'd4;
    localparam logic [3:0] OPC_SUB   = 4'd5;
    localparam logic [3:0] OPC_EQZ   = 4'd9;
    localparam logic [3:0] OPC_ILL   = 4'd15;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] depth;
    logic       desync;

    int error_count = 0;
    int check_count = 0;
    int op_count = 0;
    int rsp_count = 0;
    int accept_count = 0;
    logic [1:0] rsp_log [0:3];

    stack_sequencer_if #(.WIDTH(WIDTH)) bus ();

    stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .depth  (depth),
        .desync (desync)
    );

    always #5 clk = ~clk;

    // Registered stack: an op seen at an edge shows on tos/status/error the next cycle.
    logic [WIDTH-1:0] mem [0:3];
    logic [2:0]       cnt;
    logic [1:0]       err;

    always @(posedge clk) begin
        if (reset) begin
            cnt <= 3'd0;
            err <= ERR_NONE;
        end else begin
            case (bus.st_op)
                OP_PUSH:
                    if (cnt == MAX_STACK) err <= ERR_OVER;
                    else begin
                        mem[cnt[1:0]] <= bus.st_data;
                        cnt <= cnt + 3'd1;
                        err <= ERR_NONE;
                    end
                OP_POP:
                    if (cnt == 3'd0) err <= ERR_UNDER;
                    else begin
                        cnt <= cnt - 3'd1;
                        err <= ERR_NONE;
                    end
                OP_REPLACE:
                    if (cnt == 3'd0) err <= ERR_UNDER;
                    else begin
                        mem[cnt[1:0] - 2'd1] <= bus.st_data;
                        err <= ERR_NONE;
                    end
                default: err <= ERR_NONE;
            endcase
        end
    end

    assign bus.st_tos    = (cnt == 3'd0) ? '0 : mem[cnt[1:0] - 2'd1];
    assign bus.st_status = (cnt == 3'd0) ? ST_EMPTY : ((cnt == MAX_STACK) ? ST_FULL : ST_NONE);
    assign bus.st_error  = err;

    always @(negedge clk) begin
        if (!reset && bus.st_op != OP_NONE) op_count++;
        if (!reset && bus.rsp_valid) begin
            if (rsp_count < 4) rsp_log[rsp_count] = bus.rsp_trap;
            rsp_count++;
        end
    end

    always @(posedge clk) begin
        if (!reset && bus.cmd_valid && bus.cmd_ready) accept_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issues one command and returns the trap code and cycles from accept edge to rsp_valid.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] imm,
                                 output logic [1:0] trap, output int latency);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) checkOutput("ready_timeout", 32'd0, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_imm   = imm;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OPC_NOP;
        bus.cmd_imm   = '0;
        latency = 0;
        do begin
            @(negedge clk);
            latency++;
        end while (!bus.rsp_valid && latency < 20);
        if (!bus.rsp_valid) checkOutput("rsp_timeout", 32'd0, 32'd1);
        trap = bus.rsp_trap;
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [7:0] imm,
                           input logic [1:0] exp_trap, input int exp_latency);
        logic [1:0] trap;
        int latency;
        applyStimulus(op, imm, trap, latency);
        checkOutput({tag, "_trap"}, 32'(trap), 32'(exp_trap));
        checkOutput({tag, "_latency"}, 32'(latency), 32'(exp_latency));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OPC_NOP;
        bus.cmd_imm   = '0;
        reset         = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("reset_st_op", 32'(bus.st_op), 32'(OP_NONE));
        checkOutput("reset_st_data", 32'(bus.st_data), 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_trap", 32'(bus.rsp_trap), 32'd0);
        checkOutput("reset_depth", 32'(depth), 32'd0);
        checkOutput("reset_desync", 32'(desync), 32'd0);
        reset = 1'b0;

        // Binary op on an empty stack must trap without touching the stack.
        op_count = 0;
        run_cmd("add_empty", OPC_ADD, 8'h00, 2'd1, 2);
        checkOutput("add_empty_ops", 32'(op_count), 32'd0);
        checkOutput("add_empty_depth", 32'(depth), 32'd0);

        run_cmd("const5", OPC_CONST, 8'h05, 2'd0, 2);
        run_cmd("const3", OPC_CONST, 8'h03, 2'd0, 2);
        run_cmd("sub", OPC_SUB, 8'h00, 2'd0, 3);
        checkOutput("sub_tos", 32'(bus.st_tos), 32'h02);
        checkOutput("sub_depth", 32'(depth), 32'd1);
        run_cmd("drop", OPC_DROP, 8'h00, 2'd0, 2);
        checkOutput("drop_depth", 32'(depth), 32'd0);

        run_cmd("fill1", OPC_CONST, 8'h01, 2'd0, 2);
        run_cmd("fill2", OPC_CONST, 8'h02, 2'd0, 2);
        run_cmd("fill3", OPC_CONST, 8'h03, 2'd0, 2);
        checkOutput("full_depth", 32'(depth), 32'd3);
        checkOutput("full_status", 32'(bus.st_status), 32'(ST_FULL));
        run_cmd("const_over", OPC_CONST, 8'h04, 2'd2, 2);
        checkOutput("const_over_tos", 32'(bus.st_tos), 32'h03);
        run_cmd("dup_over", OPC_DUP, 8'h00, 2'd2, 2);
        checkOutput("dup_over_depth", 32'(depth), 32'd3);

        do_reset();
        run_cmd("constff", OPC_CONST, 8'hFF, 2'd0, 2);
        run_cmd("const01", OPC_CONST, 8'h01, 2'd0, 2);
        run_cmd("add_wrap", OPC_ADD, 8'h00, 2'd0, 3);
        checkOutput("add_wrap_tos", 32'(bus.st_tos), 32'h00);
        run_cmd("eqz1", OPC_EQZ, 8'h00, 2'd0, 2);
        checkOutput("eqz1_tos", 32'(bus.st_tos), 32'h01);
        run_cmd("eqz2", OPC_EQZ, 8'h00, 2'd0, 2);
        checkOutput("eqz2_tos", 32'(bus.st_tos), 32'h00);
        checkOutput("eqz_desync", 32'(desync), 32'd0);

        // Illegal opcode held for three cycles, then NOP for two more with valid still high.
        @(negedge clk);
        accept_count = 0;
        rsp_count    = 0;
        op_count     = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OPC_ILL;
        repeat (3) @(negedge clk);
        bus.cmd_op = OPC_NOP;
        repeat (2) @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("hold_accepts", 32'(accept_count), 32'd2);
        checkOutput("hold_rsp_count", 32'(rsp_count), 32'd2);
        checkOutput("hold_trap_ill", 32'(rsp_log[0]), 32'd3);
        checkOutput("hold_trap_nop", 32'(rsp_log[1]), 32'd0);
        checkOutput("hold_ops", 32'(op_count), 32'd0);
        checkOutput("hold_depth", 32'(depth), 32'd1);

        run_cmd("const7", OPC_CONST, 8'h07, 2'd0, 2);
        run_cmd("const9", OPC_CONST, 8'h09, 2'd0, 2);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OPC_ADD;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OPC_NOP;
        rsp_count     = 0;
        repeat (2) @(negedge clk);
        checkOutput("fetch2_st_op", 32'(bus.st_op), 32'(OP_REPLACE));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_depth", 32'(depth), 32'd0);
        checkOutput("abort_st_op", 32'(bus.st_op), 32'(OP_NONE));
        checkOutput("abort_status", 32'(bus.st_status), 32'(ST_EMPTY));
        checkOutput("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_no_rsp", 32'(rsp_count), 32'd0);
        checkOutput("final_desync", 32'(desync), 32'd0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Initiator for the operand-stack interface: accepts one WASM-style stack instruction at a time over a valid/ready command port and drives `stack`'s `op`/`data` inputs as PUSH/POP/REPLACE sequences. It reads back `tos`/`status`/`error` and computes ALU results. It sits between instruction decode and the `stack` instance. It keeps a shadow depth counter, so illegal instructions trap before any stack mutation.

## Interface
- `WIDTH`, 8: data width; must match the attached `stack`.
- `DEPTH`, 1: `stack` depth parameter; capacity `MAX_STACK = (1 << DEPTH+1) - 1`.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high; also drives the `stack` instance.
- `cmd_valid` in 1: instruction present.
- `cmd_ready` out 1: block can accept; high only in IDLE.
- `cmd_op` in 4: opcode. 0 NOP, 1 CONST, 2 DROP, 3 DUP, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR, 9 EQZ; 10–15 illegal.
- `cmd_imm` in WIDTH: immediate for CONST.
- `st_op` out 2: to `stack.op`; encodings are the `stack.svh` macros (`NONE`, `PUSH`, `POP`, `REPLACE`).
- `st_data` out WIDTH: to `stack.data`.
- `st_tos` in WIDTH: from `stack.tos`.
- `st_status` in 2: from `stack.status` (`EMPTY`/`NONE`/`FULL`).
- `st_error` in 2: from `stack.error` (`NONE`/`UNDERFLOW`/`OVERFLOW`).
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_trap` out 2: 0 OK, 1 underflow, 2 overflow, 3 illegal opcode; valid with `rsp_valid`.
- `depth` out DEPTH+2: shadow element count, 0..MAX_STACK.
- `desync` out 1: sticky; stack disagreed with shadow state.

## Operation
- States: IDLE, EXEC, FETCH2, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_op`/`cmd_imm`, go to EXEC.
- **EXEC**: check legality, then drive one stack op for exactly one cycle.
  - Illegal opcode: trap 3.
  - Underflow (trap 1):
    - DROP, DUP or EQZ with `depth`=0.
    - Binary op (ADD–XOR) with `depth`<2.
  - Overflow (trap 2): CONST or DUP with `depth`=MAX_STACK.
  - On trap: `st_op`=NONE, go to RESP with the trap code.
  - NOP: NONE → RESP.
  - CONST: PUSH `imm`, depth+1 → RESP.
  - DROP: POP, depth−1 → RESP.
  - DUP: PUSH `st_tos`, depth+1 → RESP.
  - EQZ: REPLACE (`st_tos`==0 ? 1 : 0) → RESP.
  - Binary op: POP, latch b=`st_tos`, depth−1 → FETCH2.
- **FETCH2**
  - `st_tos` now holds a (the deeper operand).
  - REPLACE with f(a,b) → RESP.
  - ADD = a+b mod 2^WIDTH. SUB = a−b mod 2^WIDTH. AND/OR/XOR bitwise.
- **RESP**
  - `rsp_valid`=1, `st_op`=NONE → IDLE.
  - Set `desync` if either holds:
    - `st_error` ≠ `NONE` after a non-trapping stack op.
    - `st_status`==`EMPTY` while `depth`≠0, or `depth`==0 while `st_status`≠`EMPTY`.
- `st_data`=0 whenever `st_op` is NONE or POP.
- A trapped instruction never changes the stack or `depth`.

## Timing
- The stack is registered. An op driven during a cycle takes effect at the closing edge; `st_tos`/`st_status`/`st_error` reflect it in the following cycle.
- Latency from accepting edge to the `rsp_valid` cycle:
  - 2 cycles for traps, NOP and unary ops (EXEC, RESP).
  - 3 cycles for binary ops (EXEC, FETCH2, RESP).
- Throughput: next command is accepted in the cycle after RESP. A `cmd_valid` held during busy cycles is accepted exactly once.
- `depth` updates at the same edge the stack executes the op.
- Reset values (sampled edge with `reset`=1):
  - state IDLE, `cmd_ready`=1.
  - `st_op`=NONE, `st_data`=0.
  - `rsp_valid`=0, `rsp_trap`=0, `depth`=0, `desync`=0.
- Reset mid-instruction abandons it with no response. Reset has priority over every handshake.

## Test plan
- Reset, then ADD with empty stack → `rsp_trap`=1 two cycles after accept. `st_op` stays NONE throughout, `depth`=0.
- CONST 5, CONST 3, SUB → `rsp_trap`=0, `st_tos`=0x02, `depth`=1. SUB response arrives 3 cycles after accept.
- CONST 1,2,3 (DEPTH=1) → `depth`=3, `st_status`=`FULL`. Then:
  - CONST 4 → trap 2, `st_tos` stays 0x03.
  - DUP → trap 2.
- CONST 0xFF, CONST 0x01, ADD → `st_tos`=0x00 (wrap). EQZ → 0x01. EQZ → 0x00. `desync`=0 throughout.
- Opcode 0xF with `cmd_valid` held high 5 cycles → accepted once, trap 3, no stack op. Held valid then accepts a following NOP normally.
- CONST 7, CONST 9, ADD, with `reset` asserted during FETCH2 → no `rsp_valid`. Next cycle: `depth`=0, `st_op`=NONE, `st_status`=`EMPTY`, `cmd_ready`=1.
